// File: rtl/cmsdk_eg_reg_pkg.sv
// Shared types and decode helpers for the example-slave register initiator.
package cmsdk_eg_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Byte lane enables for a size at the given low address bits.
  function automatic logic [3:0] strobe_decode(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] s;
    s = 4'b1111;
    case (size)
      SIZE_BYTE: s = 4'b0001 << lo;
      SIZE_HALF: s = lo[1] ? 4'b1100 : 4'b0011;
      default:   s = 4'b1111;
    endcase
    return s;
  endfunction

  // A command is legal when the size is encodable and naturally aligned.
  function automatic logic cmd_legal(input logic [1:0] size, input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~lo[0];
      SIZE_WORD: ok = (lo == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cmsdk_eg_reg_initiator.sv
// Single-outstanding register initiator: command in, one-cycle bus access,
// response out. Bus outputs are decodes of the state plus captured registers.
module cmsdk_eg_reg_initiator
  import cmsdk_eg_reg_pkg::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter int CNTWIDTH  = 16
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [1:0]           cmd_size,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDRWIDTH-1:0] addr,
  output logic                 read_en,
  output logic                 write_en,
  output logic [3:0]           byte_strobe,
  output logic [31:0]          wdata,
  input  logic [31:0]          rdata,
  output logic                 busy,
  output logic [CNTWIDTH-1:0]  txn_count
);

  state_t                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   addr_q;
  logic                   write_q;
  logic [31:0]            wdata_q;
  logic [3:0]             strb_q;
  logic [31:0]            rdata_q;
  logic                   err_q;
  logic [CNTWIDTH-1:0]    cnt_q;
  logic                   accept;
  logic                   legal;

  assign accept = (state_q == ST_IDLE) && cmd_valid;
  assign legal  = cmd_legal(cmd_size, cmd_addr[1:0]);

  // State register.
  always_ff @(posedge hclk) begin
    if (hreset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and output decode; every output is a function of registers only.
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    read_en     = 1'b0;
    write_en    = 1'b0;
    byte_strobe = 4'b0000;
    addr        = '0;
    wdata       = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = legal ? ST_ACCESS : ST_RESP;
      end
      ST_ACCESS: begin
        addr        = addr_q;
        byte_strobe = strb_q;
        write_en    = write_q;
        read_en     = ~write_q;
        wdata       = write_q ? wdata_q : 32'h0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture, read-data capture and completed-access counter.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        write_q <= cmd_write;
        wdata_q <= cmd_wdata;
        strb_q  <= strobe_decode(cmd_size, cmd_addr[1:0]);
        err_q   <= ~legal;
        // Error responses carry zero data; legal ones are filled at ACCESS end.
        if (!legal) rdata_q <= '0;
      end
      if (state_q == ST_ACCESS) begin
        rdata_q <= write_q ? 32'h0 : rdata;
        cnt_q   <= cnt_q + CNTWIDTH'(1);
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_cmsdk_eg_reg_initiator.sv
// Directed bench for the register initiator with a small behavioural slave.
module tb_cmsdk_eg_reg_initiator;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  cmd_size = 2'd0;
  logic [11:0] cmd_addr = 12'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [31:0] rdata;

  logic        cmd_ready, rsp_valid, rsp_err, read_en, write_en, busy;
  logic [31:0] rsp_rdata, wdata;
  logic [11:0] addr;
  logic [3:0]  byte_strobe;
  logic [15:0] txn_count;

  logic        cmd_ready_b, rsp_valid_b, rsp_err_b, read_en_b, write_en_b, busy_b;
  logic [31:0] rsp_rdata_b, wdata_b;
  logic [11:0] addr_b;
  logic [3:0]  byte_strobe_b;
  logic [1:0]  txn_count_b;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  cmsdk_eg_reg_initiator #(.ADDRWIDTH(12), .CNTWIDTH(16)) dut (
    .hclk(hclk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .read_en(read_en), .write_en(write_en), .byte_strobe(byte_strobe),
    .wdata(wdata), .rdata(rdata), .busy(busy), .txn_count(txn_count));

  // Narrow-counter instance runs in lockstep to observe wraparound.
  cmsdk_eg_reg_initiator #(.ADDRWIDTH(12), .CNTWIDTH(2)) dut_b (
    .hclk(hclk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .addr(addr_b), .read_en(read_en_b), .write_en(write_en_b), .byte_strobe(byte_strobe_b),
    .wdata(wdata_b), .rdata(rdata), .busy(busy_b), .txn_count(txn_count_b));

  // Behavioural slave: four RW words at 0x000-0x00C plus read-only ID registers.
  logic [31:0] mem [4];
  always_comb begin
    rdata = 32'h0;
    case (addr)
      12'hFD0: rdata = 32'h04;
      12'hFE0: rdata = 32'h17;
      12'hFE4: rdata = 32'hB8;
      12'hFE8: rdata = 32'h1B;
      12'hFF0: rdata = 32'h0D;
      12'hFF4: rdata = 32'hF0;
      12'hFF8: rdata = 32'h05;
      12'hFFC: rdata = 32'hB1;
      default: if (addr < 12'h010) rdata = mem[addr[3:2]];
    endcase
  end
  always @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < 4; i++) mem[i] <= 32'h0;
    end else if (write_en && addr < 12'h010) begin
      for (int b = 0; b < 4; b++)
        if (byte_strobe[b]) mem[addr[3:2]][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Bus monitor: counts access cycles and records the last one.
  int          bus_cnt = 0;
  logic        last_we;
  logic [3:0]  last_strb;
  logic [11:0] last_addr;
  logic [31:0] last_wdata;
  always @(negedge hclk) begin
    if (read_en || write_en) begin
      bus_cnt    = bus_cnt + 1;
      last_we    = write_en;
      last_strb  = byte_strobe;
      last_addr  = addr;
      last_wdata = wdata;
    end
  end

  // Issue one command, return once rsp_valid is seen (left in RESP, rsp_ready low).
  task automatic run_cmd(input logic w, input logic [1:0] sz, input logic [11:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e,
                         output int lat);
    int n;
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_write = w; cmd_size = sz; cmd_addr = a; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge hclk); n++; end
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    do begin @(negedge hclk); lat++; end while (!rsp_valid && lat < 20);
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout addr=%h rsp_valid=%b required 1", a, rsp_valid);
    end
    rd = rsp_rdata; e = rsp_err;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge hclk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge hclk); #1;
    checks++;
    if ({cmd_ready, busy, rsp_valid, rsp_err, read_en, write_en} !== 6'b100000 ||
        rsp_rdata !== 32'h0 || addr !== 12'h0 || byte_strobe !== 4'h0 ||
        wdata !== 32'h0 || txn_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_state rdy=%b busy=%b rv=%b err=%b re=%b we=%b rd=%h txn=%h required rdy=1 rest 0",
               cmd_ready, busy, rsp_valid, rsp_err, read_en, write_en, rsp_rdata, txn_count);
    end
    @(negedge hclk); hreset = 1'b0;
  endtask

  task automatic test_count();
    logic [31:0] rd; logic e; int lat;
    logic [1:0] exp_b [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      run_cmd(1'b0, 2'd2, 12'hFE0, 32'h0, rd, e, lat);
      checks++;
      if (txn_count_b !== exp_b[i] || txn_count !== 16'(i + 1)) begin
        errors++;
        $display("FAIL count_wrap step=%0d narrow=%0d wide=%0d required %0d/%0d",
                 i, txn_count_b, txn_count, exp_b[i], i + 1);
      end
      take_rsp();
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e; int lat; int b0;
    b0 = bus_cnt;
    run_cmd(1'b1, 2'd2, 12'h004, 32'hA5A55A5A, rd, e, lat);
    checks++;
    if (bus_cnt - b0 != 1 || last_we !== 1'b1 || last_strb !== 4'b1111 ||
        last_addr !== 12'h004 || last_wdata !== 32'hA5A55A5A || lat != 2 || e !== 1'b0) begin
      errors++;
      $display("FAIL word_write accesses=%0d we=%b strb=%b addr=%h wd=%h lat=%0d err=%b required 1 1 1111 004 a5a55a5a 2 0",
               bus_cnt - b0, last_we, last_strb, last_addr, last_wdata, lat, e);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL write_rdata got=%h required 00000000", rd);
    end
    take_rsp();
    run_cmd(1'b0, 2'd2, 12'h004, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hA5A55A5A || e !== 1'b0 || last_we !== 1'b0 || last_strb !== 4'b1111) begin
      errors++;
      $display("FAIL word_read rd=%h err=%b we=%b strb=%b required a5a55a5a 0 0 1111", rd, e, last_we, last_strb);
    end
    take_rsp();
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic e; int lat;
    run_cmd(1'b1, 2'd2, 12'h008, 32'h11223344, rd, e, lat);
    take_rsp();
    run_cmd(1'b1, 2'd0, 12'h00A, 32'h00CC0000, rd, e, lat);
    checks++;
    if (last_strb !== 4'b0100 || last_addr !== 12'h00A) begin
      errors++;
      $display("FAIL byte_strobe strb=%b addr=%h required 0100 00a", last_strb, last_addr);
    end
    take_rsp();
    run_cmd(1'b1, 2'd1, 12'h00E, 32'hBEEF0000, rd, e, lat);
    checks++;
    if (last_strb !== 4'b1100 || e !== 1'b0) begin
      errors++;
      $display("FAIL half_strobe strb=%b err=%b required 1100 0", last_strb, e);
    end
    take_rsp();
    run_cmd(1'b0, 2'd2, 12'h008, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h11CC3344) begin
      errors++;
      $display("FAIL byte_merge got=%h required 11cc3344", rd);
    end
    take_rsp();
  endtask

  task automatic test_id();
    logic [31:0] rd; logic e; int lat; logic [15:0] t0;
    t0 = txn_count;
    run_cmd(1'b0, 2'd2, 12'hFE0, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h17) begin errors++; $display("FAIL id_fe0 got=%h required 00000017", rd); end
    take_rsp();
    run_cmd(1'b0, 2'd2, 12'hFF4, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hF0) begin errors++; $display("FAIL id_ff4 got=%h required 000000f0", rd); end
    take_rsp();
    checks++;
    if (txn_count !== t0 + 16'd2) begin
      errors++;
      $display("FAIL id_txn got=%0d required %0d", txn_count, t0 + 16'd2);
    end
  endtask

  task automatic test_err();
    logic [31:0] rd; logic e; int lat; int b0; logic [15:0] t0;
    b0 = bus_cnt; t0 = txn_count;
    run_cmd(1'b1, 2'd1, 12'h001, 32'hFFFFFFFF, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_half err=%b rd=%h required 1 00000000", e, rd);
    end
    take_rsp();
    run_cmd(1'b0, 2'd3, 12'h000, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_size3 err=%b rd=%h required 1 00000000", e, rd);
    end
    take_rsp();
    run_cmd(1'b0, 2'd2, 12'h002, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL err_word_misalign err=%b required 1", e); end
    take_rsp();
    checks++;
    if (bus_cnt != b0 || txn_count !== t0) begin
      errors++;
      $display("FAIL err_no_access accesses=%0d txn=%0d required 0 %0d", bus_cnt - b0, txn_count, t0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] rd; logic e; int lat; int b0; int bad;
    run_cmd(1'b0, 2'd2, 12'hFE8, 32'h0, rd, e, lat);
    b0 = bus_cnt; bad = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 2'd2; cmd_addr = 12'h000; cmd_wdata = 32'hDEAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge hclk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1B || cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (bad != 0 || bus_cnt != b0) begin
      errors++;
      $display("FAIL stall_hold bad_cycles=%0d accesses=%0d rd=%h required 0 0 0000001b", bad, bus_cnt - b0, rsp_rdata);
    end
    take_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release rv=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_rst_resp();
    logic [31:0] rd; logic e; int lat;
    run_cmd(1'b0, 2'd2, 12'hFE0, 32'h0, rd, e, lat);
    hreset = 1'b1;
    @(posedge hclk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || txn_count !== 16'h0 || rsp_rdata !== 32'h0 ||
        {read_en, write_en, byte_strobe} !== 6'h0 || addr !== 12'h0 || wdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_in_resp rv=%b rdy=%b txn=%0d rd=%h required 0 1 0 0", rsp_valid, cmd_ready, txn_count, rsp_rdata);
    end
    @(negedge hclk); hreset = 1'b0;
  endtask

  task automatic test_rst_access();
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'd2; cmd_addr = 12'hFE4;
    @(posedge hclk); #1;
    cmd_valid = 1'b0; hreset = 1'b1;
    checks++;
    if (read_en !== 1'b1 || addr !== 12'hFE4) begin
      errors++;
      $display("FAIL rst_access_enable re=%b addr=%h required 1 fe4", read_en, addr);
    end
    @(posedge hclk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || txn_count !== 16'h0 ||
        {read_en, write_en, byte_strobe} !== 6'h0 || addr !== 12'h0 || wdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_in_access rv=%b rdy=%b txn=%0d re=%b addr=%h required 0 1 0 0 000",
               rsp_valid, cmd_ready, txn_count, read_en, addr);
    end
    @(negedge hclk); hreset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_word();
    test_byte();
    test_id();
    test_err();
    test_stall();
    test_rst_resp();
    test_rst_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmsdk_eg_reg_initiator.md
# cmsdk_eg_reg_initiator

Register-interface initiator for the example-slave register port: accepts one command at a time on a valid/ready request channel, drives a single-cycle read or write access with byte strobes, and returns read data and an error flag on a valid/ready response channel. Used by test sequencers and the bridge front end to access the example slave register block directly, without an AHB-Lite fabric.

## Interface
- ADDRWIDTH, 12: register address width.
- CNTWIDTH, 16: width of the completed-transaction counter.

- hclk  in  1  clock.
- hreset  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- cmd_addr  in  ADDRWIDTH  byte address.
- cmd_wdata  in  32  write data, already lane-aligned by the caller.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes and for errors.
- rsp_err  out  1  alignment or size error; no bus access was made.
- addr  out  ADDRWIDTH  register address to the slave.
- read_en  out  1  read strobe.
- write_en  out  1  write strobe.
- byte_strobe  out  4  byte lane enables.
- wdata  out  32  write data to the slave.
- rdata  in  32  combinational read data from the slave; valid while read_en is high.
- busy  out  1  high whenever the FSM is not in IDLE.
- txn_count  out  CNTWIDTH  number of completed bus accesses.

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, the command is captured.
    - Legal command → ACCESS.
    - Illegal command → RESP with rsp_err=1.
  - ACCESS: lasts exactly one cycle, then → RESP.
  - RESP: rsp_valid=1 until rsp_ready, then → IDLE.
- cmd_ready is high only in IDLE, so at most one transaction is outstanding.
- Legality rules:
  - Size 3 is illegal.
  - Halfword is illegal when addr[0]=1.
  - Word is illegal when addr[1:0]≠0.
- Byte strobes:
  - Byte: 4'b0001 << addr[1:0].
  - Halfword: addr[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
- Bus outputs during ACCESS:
  - addr = captured address; byte_strobe as decoded above.
  - Write: write_en=1 and wdata = captured data.
  - Read: read_en=1, byte_strobe still driven, and wdata=0.
- Bus outputs outside ACCESS: read_en, write_en, byte_strobe, addr and wdata are all 0.
- Read capture: rdata is registered into rsp_rdata at the clock edge that ends ACCESS. Reads always return the full 32-bit word; no lane extraction.
- rsp_rdata and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
- txn_count increments by 1 at the edge that ends ACCESS. Error responses do not count. The counter wraps from all-ones to 0.
- Reset values (at the first edge with hreset=1):
  - FSM = IDLE, so cmd_ready=1 and busy=0.
  - Every other output is 0, including rsp_valid, rsp_err, rsp_rdata, all bus outputs and txn_count.
- Reset mid-operation: an access in flight is abandoned and a pending response is dropped. If reset is asserted during ACCESS, the slave still sees that cycle's enable, because reset is synchronous.

## Timing
- Command accepted at edge N.
  - Legal command: ACCESS spans the cycle between edges N and N+1. rsp_valid is high from edge N+1.
  - Illegal command: rsp_valid is high from edge N+1 with no ACCESS cycle.
- If rsp_ready is high in the first RESP cycle, the FSM is back in IDLE at edge N+2. Peak rate is therefore one legal command per 3 cycles.
- No combinational path from cmd_* to the bus outputs, and none from rsp_ready to cmd_ready. All outputs are registers or pure decodes of the state register.
- If cmd_valid is asserted while the block is not in IDLE, the command is ignored; the requester must hold it until cmd_ready is high.

## Structure
- Shared package cmsdk_eg_reg_pkg contains:
  - the state enum (IDLE, ACCESS, RESP);
  - size encoding constants (SIZE_BYTE, SIZE_HALF, SIZE_WORD);
  - the strobe-decode function;
  - the legality-check function.
- No sub-module: a single FSM plus capture registers.

## Test plan
- Word write, addr 0x004, data 0xA5A55A5A, size 2 → one cycle with write_en=1, byte_strobe=4'b1111, addr=0x004. A following read of 0x004 returns rsp_rdata=0xA5A55A5A and rsp_err=0.
- Byte write, addr 0x00A, data 0x00CC0000 → byte_strobe=4'b0100. A read of 0x008 returns only byte 2 changed to 0xCC.
- Read of addr 0xFE0 → rsp_rdata=0x00000017. Read of 0xFF4 → 0x000000F0. txn_count advances by 2.
- Halfword at 0x001, and size 3 at 0x000 → rsp_err=1, rsp_rdata=0, read_en and write_en never high, txn_count unchanged.
- Read of 0xFE8 with rsp_ready held low for 5 cycles → rsp_valid stays high, rsp_rdata is stable at 0x0000001B, cmd_ready=0 throughout.
- hreset asserted in the RESP state, and separately in the ACCESS state → next edge: rsp_valid=0, cmd_ready=1, txn_count=0, all bus outputs 0.
- CNTWIDTH=2, five legal accesses → txn_count reads 1, 2, 3, 0, 1.
